// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scan-code constants and the number of data bits per frame.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } kbd_state_e;

  localparam logic [7:0] KBD_BREAK      = 8'hF0;
  localparam logic [7:0] KBD_EXT        = 8'hE0;
  localparam int         KBD_FRAME_BITS = 8;

endpackage

// File: rtl/kbd_fifo.sv
// Scan-code FIFO: circular buffer with combinational head read and a sticky
// overflow flag. A push while full is accepted only if a pop happens that cycle.
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_req_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  pop, wr_en, full;

  assign full  = (count_q == FULL_CNT);
  assign pop   = pop_req_i && (count_q != '0);
  assign wr_en = push_i && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
    if (push_i && !wr_en) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign ready_o    = (count_q != '0);
  assign data_o     = ready_o ? mem_q[rd_ptr_q] : 8'h00;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronizers, 11-bit frame FSM, abort timeout and
// scan-code FIFO. Define KBD_BREAK_FILTER_EN to drop break codes (F0 + next byte).
module ps2_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       kbd_read,
  output logic       kbd_ready,
  output logic [7:0] kbd_data,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(KBD_FRAME_BITS);

  logic          clk_meta_q, clk_s_q, prev_q, data_meta_q, data_s_q;
  logic          fall;
  kbd_state_e    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push_q, push_d;
  logic          err_q, err_d;
  logic          frame_ok;
`ifdef KBD_BREAK_FILTER_EN
  logic          skip_q, skip_d;
`endif

  assign fall     = prev_q & ~clk_s_q;
  assign frame_ok = data_s_q & (^{shift_q, parity_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_s_q     <= 1'b1;
      prev_q      <= 1'b1;
      data_meta_q <= 1'b1;
      data_s_q    <= 1'b1;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef KBD_BREAK_FILTER_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_s_q     <= clk_meta_q;
      prev_q      <= clk_s_q;
      data_meta_q <= ps2_data;
      data_s_q    <= data_meta_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
      push_q      <= push_d;
      err_q       <= err_d;
`ifdef KBD_BREAK_FILTER_EN
      skip_q      <= skip_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    push_d    = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + TW'(1);
`ifdef KBD_BREAK_FILTER_EN
    skip_d    = skip_q;
`endif
    // A stalled partial frame is dropped silently, without frame_err.
    if (state_q != ST_IDLE && !fall && to_cnt_q == TW'(TIMEOUT)) begin
      state_d = ST_IDLE;
`ifdef KBD_BREAK_FILTER_EN
      skip_d  = 1'b0;
`endif
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s_q) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            state_d   = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_d   = {data_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(KBD_FRAME_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_s_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!frame_ok) begin
            err_d = 1'b1;
          end else begin
`ifdef KBD_BREAK_FILTER_EN
            if (shift_q == KBD_BREAK) skip_d = 1'b1;
            else if (skip_q)          skip_d = 1'b0;
            else                      push_d = 1'b1;
`else
            push_d = 1'b1;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  kbd_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push_q),
    .push_data_i(shift_q),
    .pop_req_i  (kbd_read),
    .ready_o    (kbd_ready),
    .data_o     (kbd_data),
    .overflow_o (overflow)
  );

  assign frame_err = err_q;

endmodule
